// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the round countdown timer.
// Holds the FSM encoding, the wide signed arithmetic type and the clamp used on every count update.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to hold any WIDTH<=32 count plus bonus without wrapping.
    localparam int CALC_W = 34;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic logic [31:0] sat_clamp(input calc_t v, input logic [31:0] hi);
        if (v < 0) begin
            return 32'd0;
        end
        if (v > $signed({2'b00, hi})) begin
            return hi;
        end
        return v[31:0];
    endfunction

    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the clock into one-cycle ticks every TICK_DIV enabled cycles; tick is combinational
// off the counter, clear has priority, and the counter holds whenever count_en is low.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic tick
);

    localparam int PW = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = count_en && (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Round timer: saturating down-counter with run/stop, one-shot or auto-reload and runtime reload value.
// All outputs registered, one cycle after the controlling edge; no backpressure, every request acts at once.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RELOAD   = 30,
    parameter int TICK_DIV = 50000000,
    parameter int PENALTY  = 3,
    parameter int BONUS    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             sub,
    input  logic             add,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             pulse,
    output logic             expired,
    output logic             running
);

    localparam logic [31:0]      Q_MAX    = 32'((64'd1 << WIDTH) - 64'd1);
    localparam logic [WIDTH-1:0] RELOAD_V = WIDTH'(RELOAD);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] nxt_q;
    calc_t            delta;
    calc_t            nxt_raw;
    logic             tick;
    logic             arith_go;
    logic             expire;
    logic             restart;
    logic             presc_en;
    logic             presc_clear;

    always_comb begin
        load_q = (load_value == '0) ? WIDTH'(1) : load_value;

        delta = '0;
        if (add) begin
            delta = delta + calc_t'(BONUS);
        end
        if (sub) begin
            delta = delta - calc_t'(PENALTY);
        end
        if (tick) begin
            delta = delta - calc_t'(1);
        end
        nxt_raw = calc_t'(q) + delta;
        nxt_q   = WIDTH'(sat_clamp(nxt_raw, Q_MAX));

        // load_en and stop pre-empt the arithmetic path, so they also freeze the prescaler.
        arith_go    = (state == RUN) && !load_en && !stop;
        expire      = arith_go && (nxt_q == '0);
        restart     = (state == DONE) && start && !stop && !load_en;
        presc_en    = arith_go && enable;
        presc_clear = load_en || restart || expire;
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clear    (presc_clear),
        .count_en (presc_en),
        .tick     (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            q          <= RELOAD_V;
            reload_reg <= RELOAD_V;
            pulse      <= 1'b0;
            expired    <= 1'b0;
            running    <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (load_en) begin
                reload_reg <= load_q;
                q          <= load_q;
                expired    <= 1'b0;
                if (state == DONE) begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (restart) begin
                            state   <= RUN;
                            running <= 1'b1;
                            q       <= reload_reg;
                            expired <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end else if (expire) begin
                            pulse <= 1'b1;
                            if (auto_reload) begin
                                q <= reload_reg;
                            end else begin
                                q       <= '0;
                                state   <= DONE;
                                running <= 1'b0;
                                expired <= 1'b1;
                            end
                        end else begin
                            q <= nxt_q;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand-written timing corners and a random run
// against a cycle-level reference model, with TICK_DIV=1 and TICK_DIV=4 instances.
module tb_countdown_timer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       enable, start, stop, auto_reload, sub, add, load_en;
    logic [7:0] load_value;
    logic [7:0] q1, q4;
    logic       pulse1, pulse4, expired1, expired4, running1, running4;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(8), .RELOAD(5), .TICK_DIV(1), .PENALTY(3), .BONUS(4)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .auto_reload(auto_reload), .sub(sub), .add(add), .load_en(load_en),
        .load_value(load_value), .q(q1), .pulse(pulse1), .expired(expired1), .running(running1)
    );

    countdown_timer #(.WIDTH(8), .RELOAD(5), .TICK_DIV(4), .PENALTY(3), .BONUS(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .auto_reload(auto_reload), .sub(sub), .add(add), .load_en(load_en),
        .load_value(load_value), .q(q4), .pulse(pulse4), .expired(expired4), .running(running4)
    );

    typedef struct {
        bit s, sp, en, ar, sb, ad, ld;
        int lv;
        int q;
        bit p, e, r;
    } vec_t;

    // Reference model: st 0 = stopped, 1 = counting, 2 = one-shot finished.
    typedef struct {
        int st;
        int q;
        int rl;
        int pre;
        int p;
        int e;
    } mdl_t;

    function automatic vec_t mk(bit s, bit sp, bit en, bit ar, bit sb, bit ad, bit ld, int lv,
                                int eq, bit ep, bit ee, bit er);
        vec_t v;
        v.s = s; v.sp = sp; v.en = en; v.ar = ar; v.sb = sb; v.ad = ad; v.ld = ld; v.lv = lv;
        v.q = eq; v.p = ep; v.e = ee; v.r = er;
        return v;
    endfunction

    function automatic mdl_t step(mdl_t m, bit s, bit sp, bit en, bit ar, bit sb, bit ad,
                                  bit ld, int lv, int div);
        mdl_t n;
        int   v;
        bit   tk;
        n   = m;
        n.p = 0;
        if (ld) begin
            v    = (lv == 0) ? 1 : lv;
            n.rl = v;
            n.q  = v;
            n.pre = 0;
            n.e  = 0;
            if (m.st == 2) n.st = 0;
        end else if (m.st == 1 && sp) begin
            n.st = 0;
        end else if (m.st != 1) begin
            if (s && !sp) begin
                if (m.st == 2) begin
                    n.q = m.rl;
                    n.e = 0;
                    n.pre = 0;
                end
                n.st = 1;
            end
        end else begin
            tk = en && (m.pre == div - 1);
            if (en) n.pre = tk ? 0 : m.pre + 1;
            v = m.q + (ad ? 4 : 0) - (sb ? 3 : 0) - (tk ? 1 : 0);
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            if (v == 0) begin
                n.p = 1;
                n.pre = 0;
                if (ar) begin
                    n.q = m.rl;
                end else begin
                    n.q = 0;
                    n.st = 2;
                    n.e = 1;
                end
            end else begin
                n.q = v;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit sp, input bit en, input bit ar, input bit sb,
                         input bit ad, input bit ld, input int lv);
        start = s; stop = sp; enable = en; auto_reload = ar;
        sub = sb; add = ad; load_en = ld; load_value = 8'(lv);
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    vec_t tbl[$];
    mdl_t m1, m4;
    bit   rs, rsp, ren, rar, rsb, rad, rld;
    int   rlv;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Auto-reload cycling, then one-shot expiry and restart.
        tbl.push_back(mk(1,0,1,1,0,0,0,0,   5,0,0,1));
        for (int k = 0; k < 2; k++) begin
            for (int j = 4; j >= 1; j--) tbl.push_back(mk(0,0,1,1,0,0,0,0, j,0,0,1));
            tbl.push_back(mk(0,0,1,1,0,0,0,0, 5,1,0,1));
        end
        for (int j = 4; j >= 1; j--) tbl.push_back(mk(0,0,1,0,0,0,0,0, j,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,   0,1,1,0));
        for (int k = 0; k < 10; k++) tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,   5,0,0,1));
        // Sub-driven expiry and combined add/sub/tick.
        for (int j = 4; j >= 2; j--) tbl.push_back(mk(0,0,1,0,0,0,0,0, j,0,0,1));
        tbl.push_back(mk(0,0,1,0,1,0,0,0,   0,1,1,0));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,   5,0,0,1));
        tbl.push_back(mk(0,0,1,0,1,1,0,0,   5,0,0,1));
        // Stop, load, upper saturation, load of zero.
        tbl.push_back(mk(0,1,1,0,0,0,0,0,   5,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,1,253, 253,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,   253,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,1,0,0,   255,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,   254,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,   255,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,   255,0,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,1,0,   1,0,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,   1,1,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,   1,1,0,1));

        do_reset();
        check("reset q",       q1, 5);
        check("reset pulse",   pulse1, 0);
        check("reset expired", expired1, 0);
        check("reset running", running1, 0);
        check("reset q div4",  q4, 5);

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].sp, tbl[i].en, tbl[i].ar, tbl[i].sb, tbl[i].ad, tbl[i].ld, tbl[i].lv);
            cyc();
            check($sformatf("vec%0d q", i),       q1, tbl[i].q);
            check($sformatf("vec%0d pulse", i),   pulse1, tbl[i].p);
            check($sformatf("vec%0d expired", i), expired1, tbl[i].e);
            check($sformatf("vec%0d running", i), running1, tbl[i].r);
        end

        // Prescaled counting, enable freeze with phase retained, stop.
        do_reset();
        drive(1, 0, 1, 1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        repeat (3) cyc();
        check("div4 before tick", q4, 5);
        cyc();
        check("div4 first tick", q4, 4);
        repeat (2) cyc();
        enable = 1'b0;
        repeat (7) cyc();
        check("div4 frozen q", q4, 4);
        check("div4 frozen running", running4, 1);
        enable = 1'b1;
        cyc();
        check("div4 resume phase", q4, 4);
        cyc();
        check("div4 resume tick", q4, 3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("div4 stop q", q4, 3);
        check("div4 stop running", running4, 0);
        repeat (4) cyc();
        check("div4 held q", q4, 3);

        // Reset asserted between edges acts without a clock.
        do_reset();
        drive(1, 0, 1, 1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        cyc();
        cyc();
        check("pre-abort q", q1, 3);
        #2 reset = 1'b1;
        #1;
        check("async reset q", q1, 5);
        check("async reset running", running1, 0);
        check("async reset pulse", pulse1, 0);
        check("async reset expired", expired1, 0);
        @(negedge clock);
        reset = 1'b0;

        // Random traffic against the reference model on both instances.
        m1 = '{st: 0, q: 5, rl: 5, pre: 0, p: 0, e: 0};
        m4 = m1;
        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 9) == 0);
            rsp = ($urandom_range(0, 19) == 0);
            ren = ($urandom_range(0, 4) != 0);
            rar = $urandom_range(0, 1) == 1;
            rsb = ($urandom_range(0, 11) == 0);
            rad = ($urandom_range(0, 11) == 0);
            rld = ($urandom_range(0, 24) == 0);
            rlv = ($urandom_range(0, 7) == 0) ? 0 :
                  (($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(0, 255));
            drive(rs, rsp, ren, rar, rsb, rad, rld, rlv);
            m1 = step(m1, rs, rsp, ren, rar, rsb, rad, rld, rlv, 1);
            m4 = step(m4, rs, rsp, ren, rar, rsb, rad, rld, rlv, 4);
            cyc();
            check($sformatf("rnd%0d d1 q", i),       q1, m1.q);
            check($sformatf("rnd%0d d1 pulse", i),   pulse1, m1.p);
            check($sformatf("rnd%0d d1 expired", i), expired1, m1.e);
            check($sformatf("rnd%0d d1 running", i), running1, (m1.st == 1) ? 1 : 0);
            check($sformatf("rnd%0d d4 q", i),       q4, m4.q);
            check($sformatf("rnd%0d d4 pulse", i),   pulse4, m4.p);
            check($sformatf("rnd%0d d4 expired", i), expired4, m4.e);
            check($sformatf("rnd%0d d4 running", i), running4, (m4.st == 1) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Parametrised successor to the team's fixed-count pulse generators: one down-counter with a configurable width, prescaler, reload value, penalty and bonus. It adds a run/stop control, one-shot or auto-reload mode, a runtime-loadable reload value, and saturating add and subtract. It sits between the game FSM and the display/score logic and produces the round timer value and a one-cycle expiry pulse.

Parameters:
WIDTH, 8, counter and load-value width in bits
RELOAD, 30, reload value after reset; must be in the range 1 to 2^WIDTH-1
TICK_DIV, 50000000, clock cycles per count tick; must be 1 or more
PENALTY, 3, amount subtracted on a sub request
BONUS, 4, amount added on an add request

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high; forces the reset state immediately, without waiting for a clock edge
enable  in  1  1 lets ticks advance; 0 freezes the count and the prescaler
start  in  1  moves the timer from IDLE or DONE into RUN
stop  in  1  moves the timer from RUN to IDLE; the count is held
auto_reload  in  1  1 = reload on expiry; 0 = one-shot; sampled at the expiry edge
sub  in  1  subtract PENALTY, saturating at 0
add  in  1  add BONUS, saturating at 2^WIDTH-1
load_en  in  1  load a new reload value and count
load_value  in  WIDTH  new reload value; 0 is treated as 1
q  out  WIDTH  current count
pulse  out  1  one-cycle expiry strobe
expired  out  1  sticky one-shot expiry flag
running  out  1  1 while in the RUN state

Behaviour:
- Reset state: q = RELOAD, reload_reg = RELOAD, state IDLE, prescaler = 0, pulse = 0, expired = 0, running = 0.
- States:
  - IDLE: the count is held.
  - RUN: the count advances.
  - DONE: one-shot mode has expired.
- Per-edge priority, highest first: load_en, then start/stop, then the arithmetic update.
- load_en, in any state:
  - reload_reg <= max(load_value, 1); q <= the same value.
  - prescaler <= 0, expired <= 0, pulse <= 0.
  - DONE goes to IDLE; RUN stays RUN; IDLE stays IDLE.
  - All other inputs are ignored that cycle.
- start:
  - From IDLE: go to RUN with q unchanged.
  - From DONE: go to RUN with q <= reload_reg, expired <= 0, prescaler <= 0.
  - Ignored while in RUN.
- stop: RUN to IDLE; q and the prescaler are held. If start and stop are both asserted, stop wins.
- Tick generation:
  - The prescaler counts 0 to TICK_DIV-1 only when state = RUN and enable = 1.
  - tick = 1 on the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - With TICK_DIV = 1, tick = enable every RUN cycle.
- Arithmetic update, RUN only (sub and add are ignored in IDLE and DONE):
  - nxt = q + (add ? BONUS : 0) - (sub ? PENALTY : 0) - (tick ? 1 : 0).
  - Evaluate nxt signed in WIDTH+2 bits, then clamp to the range 0 to 2^WIDTH-1.
  - Simultaneous add, sub and tick combine in the same cycle.
- Expiry occurs when the clamped nxt equals 0 in RUN, from either a tick or a sub:
  - auto_reload = 1: q <= reload_reg, stay in RUN, prescaler <= 0. q never shows 0.
  - auto_reload = 0: q <= 0, go to DONE, expired <= 1. q holds 0 until start or load_en.
  - In both modes pulse <= 1 on that edge, so pulse is high for exactly one cycle. pulse is 0 on every other cycle.
- running = (state == RUN), registered.
- Reset mid-operation aborts immediately. No pulse is emitted because of a reset.
- With add = 1 alone at q = 2^WIDTH-1, q stays at 2^WIDTH-1. No wrap-around occurs in either direction.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - a saturating-clamp helper function.
- One sub-module, tick_prescaler:
  - Parameter TICK_DIV.
  - Ports clock, reset, clear, count_en, tick.
  - Width is $clog2(TICK_DIV), with a minimum of 1.
  - Instantiated once.

Test Plan:
Default configuration for all scenarios: WIDTH=8, RELOAD=5, TICK_DIV=1, PENALTY=3, BONUS=4.
1. Reset, then start=1 for one cycle, enable=1, auto_reload=1 -> q steps 5,4,3,2,1,5,4..., pulse high for one cycle coinciding with each 1->5 transition, period 5 cycles, running=1 throughout.
2. Same as 1 but auto_reload=0 -> q reaches 0, pulse one cycle, expired=1, running=0, q stays 0 for the next 10 cycles. Then start -> q=5, expired=0, running=1.
3. RUN at q=2, sub=1 for one cycle -> clamp to 0, pulse=1, one-shot goes to DONE. Repeat at q=5 with sub and add in the same cycle -> q=5 (5+4-3-1).
4. Load 253 via load_en, start, add=1 on the first RUN cycle -> q=255 (saturated), next cycle q=254. load_value=0 -> q=1, reload_reg=1.
5. TICK_DIV=4 -> q decrements every 4th cycle. Drop enable for 7 cycles mid-count -> q and prescaler frozen, then resume with the correct phase. stop at q=3 -> q held at 3, running=0.
6. Assert reset asynchronously between clock edges while in RUN at q=3 -> q=5, running=0, pulse=0, expired=0 before the next rising edge.
